// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8 data bits, optional even parity, one stop bit
//
// Purpose: oversampled serial receiver with a valid/ack output handshake.
// It reports frame, overrun and parity errors as one-cycle pulses.
// Build option: define UART_RX_PARITY_EN to expect one even-parity bit after
// data bit 7. Without the macro, parity_err is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   SYMBOL_WIDTH in   [15:0] clock cycles per bit (4..65535), latched per frame
//   Rx           in   serial line, idle high, asynchronous to clk
//   d_out        out  [7:0] received byte
//   recv_valid   out  d_out holds an unconsumed byte
//   recv_ack     in   consumer accepts d_out
//   frame_err    out  pulse: stop bit sampled low
//   overrun_err  out  pulse: good frame arrived while recv_valid was still high
//   parity_err   out  pulse: parity mismatch (UART_RX_PARITY_EN only)
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] SYMBOL_WIDTH,
  input  logic        Rx,
  output logic [7:0]  d_out,
  output logic        recv_valid,
  input  logic        recv_ack,
  output logic        frame_err,
  output logic        overrun_err,
  output logic        parity_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_sync_q, rx_sync_d;
  logic        armed_q, armed_d;
  logic [15:0] sw_q, sw_d;
  logic [15:0] t_q, t_d;
  logic [2:0]  i_q, i_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        recv_valid_q, recv_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        parity_err_q, parity_err_d;
`endif

  logic [15:0] t_inc;
  logic        bit_done;
  logic        stop_sample;
  logic        par_bad;
  logic        good_frame;

  always_comb begin
    state_d       = state_q;
    rx_meta_d     = Rx;
    rx_sync_d     = rx_meta_q;
    armed_d       = armed_q;
    sw_d          = sw_q;
    t_d           = t_q;
    i_d           = i_q;
    shift_d       = shift_q;
    d_out_d       = d_out_q;
    recv_valid_d  = recv_valid_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d         = par_q;
    parity_err_d  = 1'b0;
`endif
    stop_sample   = 1'b0;

    // Bit timer saturates instead of wrapping.
    t_inc    = (t_q == 16'hFFFF) ? t_q : t_q + 16'd1;
    bit_done = (t_q == sw_q - 16'd1);

    case (state_q)
      IDLE: begin
        t_d = '0;
        i_d = '0;
        // A start edge counts only after the line has been seen high here,
        // so a stop bit that was sampled low cannot immediately retrigger.
        if (rx_sync_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          sw_d    = SYMBOL_WIDTH;
          state_d = START;
        end
      end
      START: begin
        // Recheck the line at mid start bit to reject glitches.
        if (t_q == (sw_q >> 1) - 16'd1) begin
          t_d     = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          t_d = t_inc;
        end
      end
      DATA: begin
        if (bit_done) begin
          t_d     = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          i_d     = i_q + 3'd1;
          if (i_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          t_d = t_inc;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          t_d     = '0;
          par_d   = rx_sync_q;
          state_d = STOP;
        end else begin
          t_d = t_inc;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          t_d         = '0;
          stop_sample = 1'b1;
          state_d     = IDLE;
        end else begin
          t_d = t_inc;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_RX_PARITY_EN
    par_bad = ^{shift_q, par_q};
`else
    par_bad = 1'b0;
`endif
    good_frame = stop_sample && rx_sync_q && !par_bad;

    if (stop_sample && !rx_sync_q) begin
      frame_err_d = 1'b1;
    end
`ifdef UART_RX_PARITY_EN
    if (stop_sample && rx_sync_q && par_bad) begin
      parity_err_d = 1'b1;
    end
`endif

    // An ack in the same cycle as a new byte frees the slot for that byte.
    if (good_frame && recv_valid_q && !recv_ack) begin
      overrun_err_d = 1'b1;
    end else if (good_frame) begin
      d_out_d      = shift_q;
      recv_valid_d = 1'b1;
    end else if (recv_valid_q && recv_ack) begin
      recv_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      armed_q       <= 1'b0;
      sw_q          <= '0;
      t_q           <= '0;
      i_q           <= '0;
      shift_q       <= '0;
      d_out_q       <= 8'h00;
      recv_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_meta_d;
      rx_sync_q     <= rx_sync_d;
      armed_q       <= armed_d;
      sw_q          <= sw_d;
      t_q           <= t_d;
      i_q           <= i_d;
      shift_q       <= shift_d;
      d_out_q       <= d_out_d;
      recv_valid_q  <= recv_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign d_out       = d_out_q;
  assign recv_valid  = recv_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
